// File: rtl/eth_rx_payload_decoder.sv
`timescale 1ns/1ps
// eth_rx_payload_decoder
// Parses the Ethernet header from an 8-bit AXI-Stream RX path, filters on
// destination MAC and EtherType, strips the header and packs the payload
// into OUT_BYTES-wide words with tkeep. Flags payload length violations on
// the tlast beat (tuser) and keeps saturating accept/drop counters.
//
// Optional feature macro: RX_DECODE_VLAN_EN (802.1Q tag parsing/stripping).
//
// Ports:
//   axi_tclk, axi_tresetn        clock, synchronous active-low reset
//   enable_rx_decode             decode enable, sampled on a frame's first byte
//   rx_axis_*                    8-bit RX stream in (tready is an output)
//   tdata/tkeep/tvalid/tlast/tuser/tready   packed payload stream out
//   frames_ok, frames_dropped    saturating frame counters
module eth_rx_payload_decoder #(
    parameter logic [47:0] DEST_ADDR    = 48'h985aebdb066f,
    parameter logic        ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] ETHERTYPE    = 16'h0022,
    parameter int          OUT_BYTES    = 4,
    parameter logic [15:0] MIN_SIZE     = 16'd46,
    parameter logic [15:0] MAX_SIZE     = 16'd1500,
    parameter logic [11:0] VLAN_ID      = 12'd2,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                   axi_tclk,
    input  logic                   axi_tresetn,
    input  logic                   enable_rx_decode,
    input  logic [7:0]             rx_axis_tdata,
    input  logic                   rx_axis_tvalid,
    input  logic                   rx_axis_tlast,
    output logic                   rx_axis_tready,
    output logic [8*OUT_BYTES-1:0] tdata,
    output logic [OUT_BYTES-1:0]   tkeep,
    output logic                   tvalid,
    output logic                   tlast,
    output logic                   tuser,
    input  logic                   tready,
    output logic [CNT_WIDTH-1:0]   frames_ok,
    output logic [CNT_WIDTH-1:0]   frames_dropped
);

    localparam int                LANE_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(OUT_BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DROP} state_t;

    state_t                   state_r, state_nx;
    logic                     quiet_r;      // current input frame was cut by reset: drop uncounted
    logic [4:0]               hdr_cnt_r;
    logic [47:0]              dest_r;
    logic [7:0]               type_hi_r;
    logic [LANE_W-1:0]        lane_r;
    logic [15:0]              pay_cnt_r;
    logic [OUT_BYTES-1:0][7:0] acc_r;

    logic                     rx_fire_s, load_s, inc_ok_s, inc_drop_s;
    logic                     dest_ok_s, type_ok_s, len_err_s;
    logic [15:0]              type_s, cnt_inc_s;
    logic [8*OUT_BYTES-1:0]   word_s;
    logic [OUT_BYTES-1:0]     keep_s;

`ifdef RX_DECODE_VLAN_EN
    logic [3:0]               vid_hi_r;
    logic [7:0]               vid_lo_r;
    logic [7:0]               inner_hi_r;
    logic                     vlan_ok_s;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic type_match(input logic [15:0] t);
        return (ETHERTYPE == 16'h0000) || (t == ETHERTYPE);
    endfunction

    // Header match terms, payload length and the word to be emitted
    always_comb begin
        rx_fire_s = rx_axis_tvalid & rx_axis_tready;
        type_s    = {type_hi_r, rx_axis_tdata};
        dest_ok_s = (dest_r == DEST_ADDR) || (ACCEPT_BCAST && (dest_r == {48{1'b1}}));
        type_ok_s = type_match(type_s);
`ifdef RX_DECODE_VLAN_EN
        vlan_ok_s = ({vid_hi_r, vid_lo_r} == VLAN_ID) && type_match({inner_hi_r, rx_axis_tdata});
`endif
        cnt_inc_s = (pay_cnt_r == 16'hffff) ? 16'hffff : pay_cnt_r + 16'd1;
        len_err_s = (cnt_inc_s < MIN_SIZE) || (cnt_inc_s > MAX_SIZE);
        word_s    = '0;
        keep_s    = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            // lanes below the current one come from the accumulator, the
            // current byte bypasses it, unused upper lanes are zeroed
            if (i < int'(lane_r)) begin
                word_s[8*i +: 8] = acc_r[i];
            end else if (i == int'(lane_r)) begin
                word_s[8*i +: 8] = rx_axis_tdata;
            end else begin
                word_s[8*i +: 8] = 8'h00;
            end
            keep_s[i] = (i <= int'(lane_r));
        end
    end

    // Next-state, input ready and per-byte events
    always_comb begin
        state_nx       = state_r;
        rx_axis_tready = 1'b1;
        load_s         = 1'b0;
        inc_ok_s       = 1'b0;
        inc_drop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_fire_s) begin
                    if (rx_axis_tlast) begin
                        state_nx   = ST_IDLE;
                        inc_drop_s = ~quiet_r;
                    end else if (quiet_r || !enable_rx_decode) begin
                        state_nx = ST_DROP;
                    end else begin
                        state_nx = ST_HDR;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (rx_fire_s) begin
                    if (rx_axis_tlast) begin
                        state_nx   = ST_IDLE;
                        inc_drop_s = 1'b1;
                    end else if (hdr_cnt_r == 5'd13) begin
`ifdef RX_DECODE_VLAN_EN
                        if (type_s == 16'h8100) begin
                            state_nx = ST_HDR;
                        end else if (dest_ok_s && type_ok_s) begin
                            state_nx = ST_PAYLOAD;
                        end else begin
                            state_nx = ST_DROP;
                        end
                    end else if (hdr_cnt_r == 5'd17) begin
                        if (dest_ok_s && vlan_ok_s) begin
                            state_nx = ST_PAYLOAD;
                        end else begin
                            state_nx = ST_DROP;
                        end
`else
                        if (dest_ok_s && type_ok_s) begin
                            state_nx = ST_PAYLOAD;
                        end else begin
                            state_nx = ST_DROP;
                        end
`endif
                    end else begin
                        state_nx = ST_HDR;
                    end
                end else begin
                    state_nx = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                // a byte is only taken when the output register can take a word
                rx_axis_tready = ~tvalid | tready;
                if (rx_fire_s) begin
                    load_s = (lane_r == LAST_LANE) || rx_axis_tlast;
                    if (rx_axis_tlast) begin
                        state_nx   = ST_IDLE;
                        inc_ok_s   = ~len_err_s;
                        inc_drop_s = len_err_s;
                    end else begin
                        state_nx = ST_PAYLOAD;
                    end
                end else begin
                    state_nx = ST_PAYLOAD;
                end
            end
            ST_DROP: begin
                if (rx_fire_s && rx_axis_tlast) begin
                    state_nx   = ST_IDLE;
                    inc_drop_s = ~quiet_r;
                end else begin
                    state_nx = ST_DROP;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register; reset remembers whether it interrupted a frame
    always_ff @(posedge axi_tclk) begin
        if (!axi_tresetn) begin
            state_r <= ST_IDLE;
            quiet_r <= (quiet_r || (state_r != ST_IDLE)) && !(rx_fire_s && rx_axis_tlast);
        end else begin
            state_r <= state_nx;
            if (rx_fire_s && rx_axis_tlast) begin
                quiet_r <= 1'b0;
            end
        end
    end

    // Header byte counter and field capture
    always_ff @(posedge axi_tclk) begin
        if (!axi_tresetn) begin
            hdr_cnt_r  <= 5'd0;
            dest_r     <= 48'h0;
            type_hi_r  <= 8'h00;
`ifdef RX_DECODE_VLAN_EN
            vid_hi_r   <= 4'h0;
            vid_lo_r   <= 8'h00;
            inner_hi_r <= 8'h00;
`endif
        end else if (rx_fire_s && (state_r == ST_IDLE)) begin
            hdr_cnt_r <= 5'd1;
            dest_r    <= {dest_r[39:0], rx_axis_tdata};
        end else if (rx_fire_s && (state_r == ST_HDR)) begin
            hdr_cnt_r <= hdr_cnt_r + 5'd1;
            if (hdr_cnt_r < 5'd6) begin
                dest_r <= {dest_r[39:0], rx_axis_tdata};
            end
            if (hdr_cnt_r == 5'd12) begin
                type_hi_r <= rx_axis_tdata;
            end
`ifdef RX_DECODE_VLAN_EN
            if (hdr_cnt_r == 5'd14) begin
                vid_hi_r <= rx_axis_tdata[3:0];
            end
            if (hdr_cnt_r == 5'd15) begin
                vid_lo_r <= rx_axis_tdata;
            end
            if (hdr_cnt_r == 5'd16) begin
                inner_hi_r <= rx_axis_tdata;
            end
`endif
        end
    end

    // Payload lane/length tracking and byte accumulator
    always_ff @(posedge axi_tclk) begin
        if (!axi_tresetn) begin
            lane_r    <= {LANE_W{1'b0}};
            pay_cnt_r <= 16'd0;
            acc_r     <= '0;
        end else if ((state_r == ST_HDR) && (state_nx == ST_PAYLOAD)) begin
            lane_r    <= {LANE_W{1'b0}};
            pay_cnt_r <= 16'd0;
        end else if (rx_fire_s && (state_r == ST_PAYLOAD)) begin
            acc_r[lane_r] <= rx_axis_tdata;
            pay_cnt_r     <= cnt_inc_s;
            if ((lane_r == LAST_LANE) || rx_axis_tlast) begin
                lane_r <= {LANE_W{1'b0}};
            end else begin
                lane_r <= lane_r + LANE_W'(1);
            end
        end
    end

    // Output register: load a word, or retire the held one on tready
    always_ff @(posedge axi_tclk) begin
        if (!axi_tresetn) begin
            tdata  <= '0;
            tkeep  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
        end else if (load_s) begin
            tdata  <= word_s;
            tkeep  <= keep_s;
            tvalid <= 1'b1;
            tlast  <= rx_axis_tlast;
            tuser  <= rx_axis_tlast && len_err_s;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
        end
    end

    // Saturating frame counters
    always_ff @(posedge axi_tclk) begin
        if (!axi_tresetn) begin
            frames_ok      <= '0;
            frames_dropped <= '0;
        end else begin
            if (inc_ok_s) begin
                frames_ok <= sat_inc(frames_ok);
            end
            if (inc_drop_s) begin
                frames_dropped <= sat_inc(frames_dropped);
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_payload_decoder.sv
`timescale 1ns/1ps
// Directed table-driven bench for eth_rx_payload_decoder (OUT_BYTES=4).
module tb_eth_rx_payload_decoder;

`ifdef RX_DECODE_VLAN_EN
    localparam bit VL = 1'b1;
`else
    localparam bit VL = 1'b0;
`endif
    localparam logic [47:0] LOCAL = 48'h985aebdb066f;
    localparam logic [47:0] BCAST = 48'hffffffffffff;

    logic        clk = 1'b0, rstn = 1'b0, en = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        rxv = 1'b0, rxl = 1'b0, rx_ready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast, tuser, tready = 1'b1, tog = 1'b0;
    logic [15:0] fok, fdrop;

    eth_rx_payload_decoder dut (
        .axi_tclk(clk), .axi_tresetn(rstn), .enable_rx_decode(en),
        .rx_axis_tdata(rxd), .rx_axis_tvalid(rxv), .rx_axis_tlast(rxl),
        .rx_axis_tready(rx_ready), .tdata(tdata), .tkeep(tkeep),
        .tvalid(tvalid), .tlast(tlast), .tuser(tuser), .tready(tready),
        .frames_ok(fok), .frames_dropped(fdrop)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int bp_viol = 0, bp_seen = 0;
    bit pay_flag = 1'b0;
    logic [7:0]  fq[$];
    int          hdr_len = 14;
    logic [31:0] md[$];
    logic [3:0]  mk[$];
    logic        ml[$], mu[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // output monitor and back-pressure observation, away from the active edge
    always @(negedge clk) begin
        if (rstn && tvalid && tready) begin
            md.push_back(tdata); mk.push_back(tkeep);
            ml.push_back(tlast); mu.push_back(tuser);
        end
        if (rstn && pay_flag && tvalid && !tready) begin
            bp_seen++;
            if (rx_ready) bp_viol++;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            tready = tog ? ~tready : 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        md.delete(); mk.delete(); ml.delete(); mu.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic drain();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [47:0] dest, input logic [15:0] et, input bit tag,
                         input logic [15:0] tci, input int plen, input logic [7:0] st);
        fq.delete();
        for (int i = 0; i < 6; i++) fq.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fq.push_back(8'h10 + 8'(i));
        fq.push_back(et[15:8]); fq.push_back(et[7:0]);
        hdr_len = 14;
        if (tag) begin
            fq.push_back(tci[15:8]); fq.push_back(tci[7:0]);
            fq.push_back(8'h00); fq.push_back(8'h22);
            hdr_len = 18;
        end
        for (int i = 0; i < plen; i++) fq.push_back(st + 8'(i));
    endtask

    // drive bytes [from,to); tlast on the final one when 'last' is set
    task automatic send_range(input int from, input int to, input bit last);
        for (int i = from; i < to; i++) begin
            int n;
            n = 0;
            rxd = fq[i]; rxv = 1'b1; rxl = last && (i == to - 1);
            pay_flag = (i >= hdr_len);
            @(negedge clk);
            while (!rx_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (n >= 200) begin
                checks++; errors++;
                $display("FAIL rx_timeout: byte %0d not accepted within 200 cycles", i);
            end
            @(posedge clk); #1;
        end
        rxv = 1'b0; rxl = 1'b0; pay_flag = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          rst;
        bit          en;
        logic [47:0] dest;
        logic [15:0] et;
        bit          tag;
        logic [15:0] tci;
        int          plen;
        logic [7:0]  st;
        bit          tog;
        int          beats;
        logic [3:0]  keep;
        bit          user;
        logic [31:0] first;
        int          ok;
        int          drop;
    } vec_t;

    function automatic vec_t mkv(string n, bit r, bit e, logic [47:0] d, logic [15:0] t, bit tg,
                                 logic [15:0] tci, int pl, logic [7:0] st, bit tgl, int bt,
                                 logic [3:0] kp, bit us, logic [31:0] fst, int ok, int dr);
        vec_t v;
        v.name = n; v.rst = r; v.en = e; v.dest = d; v.et = t; v.tag = tg; v.tci = tci;
        v.plen = pl; v.st = st; v.tog = tgl; v.beats = bt; v.keep = kp; v.user = us;
        v.first = fst; v.ok = ok; v.drop = dr;
        return v;
    endfunction

    vec_t vt[13];

    initial begin
        vt[0]  = mkv("good64",   1, 1, LOCAL, 16'h0022, 0, 16'h0, 64,   8'h01, 0, 16,  4'hf, 0, 32'h04030201, 1, 0);
        vt[1]  = mkv("toggle50", 1, 1, LOCAL, 16'h0022, 0, 16'h0, 50,   8'h01, 1, 13,  4'h3, 0, 32'h04030201, 1, 0);
        vt[2]  = mkv("wrongdst", 1, 1, 48'h112233445566, 16'h0022, 0, 16'h0, 64, 8'h01, 0, 0, 4'h0, 0, 32'h0, 0, 1);
        vt[3]  = mkv("bcast46",  0, 1, BCAST, 16'h0022, 0, 16'h0, 46,   8'h20, 0, 12,  4'h3, 0, 32'h23222120, 1, 1);
        vt[4]  = mkv("type0800", 0, 1, LOCAL, 16'h0800, 0, 16'h0, 46,   8'h20, 0, 0,   4'h0, 0, 32'h0, 1, 2);
        vt[5]  = mkv("disabled", 0, 0, LOCAL, 16'h0022, 0, 16'h0, 46,   8'h20, 0, 0,   4'h0, 0, 32'h0, 1, 3);
        vt[6]  = mkv("min45",    1, 1, LOCAL, 16'h0022, 0, 16'h0, 45,   8'h00, 0, 12,  4'h1, 1, 32'h03020100, 0, 1);
        vt[7]  = mkv("max1500",  0, 1, LOCAL, 16'h0022, 0, 16'h0, 1500, 8'h00, 0, 375, 4'hf, 0, 32'h03020100, 1, 1);
        vt[8]  = mkv("max1501",  0, 1, LOCAL, 16'h0022, 0, 16'h0, 1501, 8'h00, 0, 376, 4'h1, 1, 32'h03020100, 1, 2);
        vt[9]  = mkv("vlan2",    1, 1, LOCAL, 16'h8100, 1, 16'h0002, 48, 8'h60, 0, VL ? 12 : 0, VL ? 4'hf : 4'h0,
                     0, VL ? 32'h63626160 : 32'h0, VL ? 1 : 0, VL ? 0 : 1);
        vt[10] = mkv("vlan3",    0, 1, LOCAL, 16'h8100, 1, 16'h0003, 48, 8'h60, 0, 0, 4'h0, 0, 32'h0,
                     VL ? 1 : 0, VL ? 1 : 2);
        vt[11] = mkv("len10",    1, 1, LOCAL, 16'h0022, 0, 16'h0, 10,   8'h50, 0, 3,   4'h3, 1, 32'h53525150, 0, 1);
        vt[12] = mkv("len1600",  0, 1, LOCAL, 16'h0022, 0, 16'h0, 1600, 8'h00, 0, 400, 4'hf, 1, 32'h03020100, 0, 2);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0); chk("rst_tlast", tlast, 0); chk("rst_tuser", tuser, 0);
        chk("rst_tkeep", tkeep, 0);   chk("rst_tdata", tdata, 0); chk("rst_ok", fok, 0);
        chk("rst_drop", fdrop, 0);    chk("rst_rx_ready", rx_ready, 1);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 13; k++) begin
            int idx, bad, mid, lb;
            if (vt[k].rst) do_reset();
            tog = vt[k].tog; en = vt[k].en;
            bp_viol = 0; bp_seen = 0;
            clear_mon();
            build(vt[k].dest, vt[k].et, vt[k].tag, vt[k].tci, vt[k].plen, vt[k].st);
            send_range(0, fq.size(), 1'b1);
            drain();
            tog = 1'b0; en = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("%s/beats", vt[k].name), md.size(), vt[k].beats);
            chk($sformatf("%s/frames_ok", vt[k].name), fok, vt[k].ok);
            chk($sformatf("%s/frames_dropped", vt[k].name), fdrop, vt[k].drop);
            if (vt[k].beats > 0 && md.size() > 0) begin
                lb = md.size() - 1;
                chk($sformatf("%s/first_tdata", vt[k].name), md[0], vt[k].first);
                chk($sformatf("%s/last_tkeep", vt[k].name), mk[lb], vt[k].keep);
                chk($sformatf("%s/last_tlast", vt[k].name), ml[lb], 1);
                chk($sformatf("%s/last_tuser", vt[k].name), mu[lb], vt[k].user);
                idx = 0; bad = 0; mid = 0;
                for (int b = 0; b <= lb; b++) begin
                    if (b < lb && (mk[b] != 4'hf || ml[b] || mu[b])) mid++;
                    for (int l = 0; l < 4; l++) begin
                        if (mk[b][l]) begin
                            if (md[b][8*l +: 8] !== 8'(vt[k].st + 8'(idx))) bad++;
                            idx++;
                        end
                    end
                end
                chk($sformatf("%s/mid_beats", vt[k].name), mid, 0);
                chk($sformatf("%s/payload_bad", vt[k].name), bad, 0);
                chk($sformatf("%s/payload_cnt", vt[k].name), idx, vt[k].plen);
            end
            if (vt[k].tog) begin
                chk($sformatf("%s/bp_ready_violations", vt[k].name), bp_viol, 0);
                chk($sformatf("%s/bp_observed", vt[k].name), (bp_seen > 0), 1);
            end
        end

        // header runts following the length-error frames (dropped count was 2)
        clear_mon();
        build(LOCAL, 16'h0022, 0, 16'h0, 0, 8'h00);
        send_range(0, 9, 1'b1);
        drain();
        chk("runt9/beats", md.size(), 0);
        chk("runt9/frames_dropped", fdrop, 3);
        send_range(0, 14, 1'b1);
        drain();
        chk("runt14/beats", md.size(), 0);
        chk("runt14/frames_dropped", fdrop, 4);
        send_range(0, 1, 1'b1);
        drain();
        chk("single_byte/frames_dropped", fdrop, 5);
        chk("single_byte/frames_ok", fok, 0);

        // reset in the middle of a payload: remnant discarded without counting
        do_reset();
        clear_mon();
        build(LOCAL, 16'h0022, 0, 16'h0, 60, 8'h80);
        send_range(0, 34, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst/tvalid", tvalid, 0); chk("midrst/tdata", tdata, 0);
        chk("midrst/tkeep", tkeep, 0);   chk("midrst/tlast", tlast, 0);
        chk("midrst/ok", fok, 0);        chk("midrst/drop", fdrop, 0);
        @(posedge clk); #1 rstn = 1'b1;
        clear_mon();
        send_range(34, fq.size(), 1'b1);
        drain();
        chk("remnant/beats", md.size(), 0);
        chk("remnant/frames_dropped", fdrop, 0);
        build(LOCAL, 16'h0022, 0, 16'h0, 46, 8'h30);
        send_range(0, fq.size(), 1'b1);
        drain();
        chk("after_rst/beats", md.size(), 12);
        if (md.size() > 0) chk("after_rst/first_tdata", md[0], 32'h33323130);
        chk("after_rst/frames_ok", fok, 1);
        chk("after_rst/frames_dropped", fdrop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
